// File: rtl/intra_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intra_pkg : shared types and sizing helpers for the intra block fetcher    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package intra_pkg;
  localparam int c_blk_min = 4;
  localparam int c_blk_mid = 8;
  localparam int c_blk_max = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RG_BLK  = 2'd0,
    RG_TOP  = 2'd1,
    RG_LEFT = 2'd2
  } region_t;

  typedef enum logic [1:0] {
    SB_NONE = 2'd0,
    SB_DC   = 2'd1,
    SB_REP  = 2'd2
  } subst_t;

  function automatic bit blk_legal(input int blk);
    return (blk == c_blk_min) || (blk == c_blk_mid) || (blk == c_blk_max);
  endfunction

  function automatic int n_blk(input int blk);
    return blk * blk;
  endfunction

  function automatic int n_top(input int blk);
    return 2 * blk;
  endfunction

  function automatic int n_left(input int blk);
    return blk + 1;
  endfunction

  function automatic int dc_val(input int pix_w);
    return 1 << (pix_w - 1);
  endfunction
endpackage
`default_nettype wire

// File: rtl/intra_fetch_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intra_fetch_addr_gen : maps a fetch slot to read strobe, address and the   |
// | destination/substitution of the returned pixel.            Rev 1.0        |
// +----------------------------------------------------------------------------+
module intra_fetch_addr_gen
  import intra_pkg::*;
#(
  parameter int FRAME_W = 256,
  parameter int BLK     = 4,
  parameter int ADDR_W  = 16,
  parameter int CW      = 5,
  parameter int IW      = 4,
  parameter int XW      = 6,
  parameter int YW      = 6
) (
  input  logic              active,
  input  logic [CW-1:0]     slot,
  input  logic [XW-1:0]     bx,
  input  logic [YW-1:0]     by,
  input  logic              top_av,
  input  logic              left_av,
  input  logic              corner_av,
  input  logic              tr_av,
  output logic              src_en,
  output logic              rec_en,
  output logic [ADDR_W-1:0] addr,
  output region_t           region,
  output logic [IW-1:0]     idx,
  output subst_t            subst
);
  localparam int c_lb    = $clog2(BLK);
  localparam int c_n_blk = n_blk(BLK);
  localparam int c_n_top = n_top(BLK);
  localparam logic [ADDR_W-1:0] c_fw  = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

  logic [ADDR_W-1:0] w_x0, w_y0, w_x, w_y;
  logic [CW-1:0]     w_rel;
  logic              w_avail, w_src;

  assign w_x0 = ADDR_W'(bx) << c_lb;
  assign w_y0 = ADDR_W'(by) << c_lb;

  always_comb begin
    region  = RG_BLK;
    idx     = '0;
    subst   = SB_NONE;
    w_avail = 1'b1;
    w_src   = 1'b1;
    w_x     = w_x0;
    w_y     = w_y0;
    w_rel   = '0;
    if (slot < CW'(c_n_blk)) begin
      idx = IW'(slot);
      w_x = w_x0 + ADDR_W'(slot[c_lb-1:0]);
      w_y = w_y0 + ADDR_W'(slot >> c_lb);
    end else if (slot < CW'(c_n_blk + c_n_top)) begin
      w_rel  = slot - CW'(c_n_blk);
      region = RG_TOP;
      idx    = IW'(w_rel);
      w_src  = 1'b0;
      w_x    = w_x0 + ADDR_W'(w_rel);
      w_y    = w_y0 - c_one;
      if (w_rel < CW'(BLK)) begin
        w_avail = top_av;
        subst   = SB_DC;
      end else begin
        // Top-right falls back to the last top pixel, which is already DC if top is missing
        w_avail = tr_av;
        subst   = SB_REP;
      end
    end else begin
      w_rel  = slot - CW'(c_n_blk + c_n_top);
      region = RG_LEFT;
      idx    = IW'(w_rel);
      w_src  = 1'b0;
      w_x    = w_x0 - c_one;
      subst  = SB_DC;
      if (w_rel == '0) begin
        w_avail = corner_av;
        w_y     = w_y0 - c_one;
      end else begin
        w_avail = left_av;
        w_y     = w_y0 + ADDR_W'(w_rel) - c_one;
      end
    end
    if (w_avail) subst = SB_NONE;
  end

  assign src_en = active & w_src;
  assign rec_en = active & ~w_src & w_avail;
  assign addr   = (src_en | rec_en) ? (w_y * c_fw + w_x) : '0;
endmodule
`default_nettype wire

// File: rtl/intra_block_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intra_block_fetcher : fetches a source block plus its top/left/corner      |
// | reconstructed neighbours for intra prediction.             Rev 1.0        |
// +----------------------------------------------------------------------------+
module intra_block_fetcher
  import intra_pkg::*;
#(
  parameter int FRAME_W = 256,
  parameter int FRAME_H = 256,
  parameter int BLK     = 4,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = $clog2(FRAME_W * FRAME_H)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [$clog2(FRAME_W/BLK)-1:0]  blk_x,
  input  logic [$clog2(FRAME_H/BLK)-1:0]  blk_y,
  input  logic                            top_right_avail,
  output logic                            src_rd_en,
  output logic [ADDR_W-1:0]               src_rd_addr,
  input  logic [PIX_W-1:0]                src_rd_data,
  output logic                            rec_rd_en,
  output logic [ADDR_W-1:0]               rec_rd_addr,
  input  logic [PIX_W-1:0]                rec_rd_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BLK*BLK*PIX_W-1:0]        blk_pix,
  output logic [2*BLK*PIX_W-1:0]          top_pix,
  output logic [(BLK+1)*PIX_W-1:0]        left_pix
);
  localparam int c_xw     = $clog2(FRAME_W / BLK);
  localparam int c_yw     = $clog2(FRAME_H / BLK);
  localparam int c_n_slot = n_blk(BLK) + n_top(BLK) + n_left(BLK);
  localparam int c_cw     = $clog2(c_n_slot);
  localparam int c_iw     = $clog2(n_blk(BLK));
  localparam logic [PIX_W-1:0] c_dc     = PIX_W'(dc_val(PIX_W));
  localparam logic [c_xw-1:0]  c_last_x = c_xw'(FRAME_W / BLK - 1);
  localparam logic [c_cw-1:0]  c_last_c = c_cw'(c_n_slot - 1);

  generate
    if (!blk_legal(BLK)) begin : g_bad_blk
      $error("intra_block_fetcher: BLK must be 4, 8 or 16");
    end
    if ((FRAME_W % BLK) != 0 || (FRAME_H % BLK) != 0) begin : g_bad_frame
      $error("intra_block_fetcher: FRAME_W and FRAME_H must be multiples of BLK");
    end
  endgenerate

  state_t            r_state;
  logic [c_cw-1:0]   r_cnt;
  logic [c_xw-1:0]   r_bx;
  logic [c_yw-1:0]   r_by;
  logic              r_tra, r_in_ready, r_out_valid;
  logic              w_active, w_top_av, w_left_av, w_corner_av, w_tr_av;
  logic              w_src_en, w_rec_en;
  logic [ADDR_W-1:0] w_addr;
  region_t           w_region, r_cap_region;
  logic [c_iw-1:0]   w_idx, r_cap_idx;
  subst_t            w_subst, r_cap_subst;
  logic              r_cap_vld;
  logic [PIX_W-1:0]  w_cap_pix;

  assign w_active    = (r_state == ST_FETCH);
  assign w_top_av    = (r_by != '0);
  assign w_left_av   = (r_bx != '0);
  assign w_corner_av = w_top_av & w_left_av;
  assign w_tr_av     = w_top_av & r_tra & (r_bx != c_last_x);

  intra_fetch_addr_gen #(
    .FRAME_W (FRAME_W),
    .BLK     (BLK),
    .ADDR_W  (ADDR_W),
    .CW      (c_cw),
    .IW      (c_iw),
    .XW      (c_xw),
    .YW      (c_yw)
  ) u_addr_gen (
    .active    (w_active),
    .slot      (r_cnt),
    .bx        (r_bx),
    .by        (r_by),
    .top_av    (w_top_av),
    .left_av   (w_left_av),
    .corner_av (w_corner_av),
    .tr_av     (w_tr_av),
    .src_en    (w_src_en),
    .rec_en    (w_rec_en),
    .addr      (w_addr),
    .region    (w_region),
    .idx       (w_idx),
    .subst     (w_subst)
  );

  assign src_rd_en   = w_src_en;
  assign rec_rd_en   = w_rec_en;
  assign src_rd_addr = w_src_en ? w_addr : '0;
  assign rec_rd_addr = w_rec_en ? w_addr : '0;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bx        <= '0;
      r_by        <= '0;
      r_tra       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_bx       <= blk_x;
            r_by       <= blk_y;
            r_tra      <= top_right_avail;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_FETCH;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (r_cnt == c_last_c) begin
            r_cnt   <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        default: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Slot descriptor travels one cycle alongside the memory read latency
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cap_vld    <= 1'b0;
      r_cap_region <= RG_BLK;
      r_cap_idx    <= '0;
      r_cap_subst  <= SB_NONE;
    end else begin
      r_cap_vld    <= w_active;
      r_cap_region <= w_region;
      r_cap_idx    <= w_idx;
      r_cap_subst  <= w_subst;
    end
  end

  always_comb begin
    w_cap_pix = (r_cap_region == RG_BLK) ? src_rd_data : rec_rd_data;
    if (r_cap_subst == SB_DC)  w_cap_pix = c_dc;
    if (r_cap_subst == SB_REP) w_cap_pix = top_pix[(BLK-1)*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blk_pix  <= '0;
      top_pix  <= '0;
      left_pix <= '0;
    end else if (r_cap_vld) begin
      case (r_cap_region)
        RG_BLK:  blk_pix[r_cap_idx*PIX_W +: PIX_W]  <= w_cap_pix;
        RG_TOP:  top_pix[r_cap_idx*PIX_W +: PIX_W]  <= w_cap_pix;
        default: left_pix[r_cap_idx*PIX_W +: PIX_W] <= w_cap_pix;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_intra_block_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_intra_block_fetcher : directed bench for BLK=4/8/16 fetcher instances   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_intra_block_fetcher;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, out_ready, tra;
  logic [5:0] bx, by;
  logic [2:0] ivld;
  int         sel;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic        irdy [3];
  logic        ovld [3];
  logic        sen  [3];
  logic        ren  [3];
  logic [15:0] saddr [3];
  logic [15:0] raddr [3];
  logic [7:0]  sdata [3];
  logic [7:0]  rdata [3];
  logic [127:0]  bp0;  logic [63:0]  tp0; logic [39:0]  lp0;
  logic [511:0]  bp1;  logic [127:0] tp1; logic [71:0]  lp1;
  logic [2047:0] bp2;  logic [255:0] tp2; logic [135:0] lp2;

  intra_block_fetcher #(.BLK(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .blk_x(bx[5:0]), .blk_y(by[5:0]), .top_right_avail(tra),
    .src_rd_en(sen[0]), .src_rd_addr(saddr[0]), .src_rd_data(sdata[0]),
    .rec_rd_en(ren[0]), .rec_rd_addr(raddr[0]), .rec_rd_data(rdata[0]),
    .out_valid(ovld[0]), .out_ready(out_ready),
    .blk_pix(bp0), .top_pix(tp0), .left_pix(lp0));

  intra_block_fetcher #(.BLK(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .blk_x(bx[4:0]), .blk_y(by[4:0]), .top_right_avail(tra),
    .src_rd_en(sen[1]), .src_rd_addr(saddr[1]), .src_rd_data(sdata[1]),
    .rec_rd_en(ren[1]), .rec_rd_addr(raddr[1]), .rec_rd_data(rdata[1]),
    .out_valid(ovld[1]), .out_ready(out_ready),
    .blk_pix(bp1), .top_pix(tp1), .left_pix(lp1));

  intra_block_fetcher #(.BLK(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(ivld[2]), .in_ready(irdy[2]),
    .blk_x(bx[3:0]), .blk_y(by[3:0]), .top_right_avail(tra),
    .src_rd_en(sen[2]), .src_rd_addr(saddr[2]), .src_rd_data(sdata[2]),
    .rec_rd_en(ren[2]), .rec_rd_addr(raddr[2]), .rec_rd_data(rdata[2]),
    .out_valid(ovld[2]), .out_ready(out_ready),
    .blk_pix(bp2), .top_pix(tp2), .left_pix(lp2));

  // Frame contents depend on both x and y so row/column mix-ups are visible
  function automatic logic [7:0] src_f(input logic [15:0] a);
    return 8'(a[7:0] + a[15:8] * 8'd17);
  endfunction

  function automatic logic [7:0] rec_f(input logic [15:0] a);
    return 8'(a[7:0] * 8'd3 + a[15:8] * 8'd29 + 8'd5);
  endfunction

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sen[k]) sdata[k] <= src_f(saddr[k]);
      if (ren[k]) rdata[k] <= rec_f(raddr[k]);
    end
  end

  logic          m_irdy, m_ovld, m_sen, m_ren;
  logic [15:0]   m_saddr, m_raddr;
  logic [2047:0] m_blk;
  logic [255:0]  m_top;
  logic [135:0]  m_left;

  always_comb begin
    m_irdy  = irdy[sel];
    m_ovld  = ovld[sel];
    m_sen   = sen[sel];
    m_ren   = ren[sel];
    m_saddr = saddr[sel];
    m_raddr = raddr[sel];
    m_blk   = '0;
    m_top   = '0;
    m_left  = '0;
    case (sel)
      0: begin m_blk = 2048'(bp0); m_top = 256'(tp0); m_left = 136'(lp0); end
      1: begin m_blk = 2048'(bp1); m_top = 256'(tp1); m_left = 136'(lp1); end
      default: begin m_blk = bp2; m_top = tp2; m_left = lp2; end
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
    int k;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      k = 0;
      while (k < 255 && obs[k*8 +: 8] === exp[k*8 +: 8]) k++;
      $error("FAIL %s: pixel %0d observed %0h expected %0h", tag, k, obs[k*8 +: 8], exp[k*8 +: 8]);
    end
  endtask

  task automatic build_exp(input int b, input int xb, input int yb, input bit tr,
                           output logic [2047:0] eb, output logic [255:0] et,
                           output logic [135:0] el);
    int x0, y0;
    bit t_av, l_av, r_av;
    x0 = xb * b;
    y0 = yb * b;
    t_av = (yb != 0);
    l_av = (xb != 0);
    r_av = t_av && tr && (xb != 256 / b - 1);
    eb = '0; et = '0; el = '0;
    for (int i = 0; i < b * b; i++)
      eb[i*8 +: 8] = src_f(16'((y0 + i / b) * 256 + x0 + i % b));
    for (int i = 0; i < b; i++)
      et[i*8 +: 8] = t_av ? rec_f(16'((y0 - 1) * 256 + x0 + i)) : 8'd128;
    for (int i = b; i < 2 * b; i++)
      et[i*8 +: 8] = r_av ? rec_f(16'((y0 - 1) * 256 + x0 + i)) : et[(b-1)*8 +: 8];
    el[7:0] = (t_av && l_av) ? rec_f(16'((y0 - 1) * 256 + x0 - 1)) : 8'd128;
    for (int i = 1; i <= b; i++)
      el[i*8 +: 8] = l_av ? rec_f(16'((y0 + i - 1) * 256 + x0 - 1)) : 8'd128;
  endtask

  task automatic start_req(input int s, input int xb, input int yb, input bit tr);
    sel = s; bx = 6'(xb); by = 6'(yb); tra = tr;
    #1;
    check_val("in_ready_idle", 64'(m_irdy), 64'd1);
    ivld = 3'(1 << s);
    @(posedge clk); #1;
    ivld = '0;
  endtask

  task automatic wait_done(input int b, input int xb, input int yb, input bit tr);
    int cyc, nsrc, nrec, nbad, exp_rec;
    bit t_av, l_av, r_av;
    cyc = 1; nsrc = 0; nrec = 0; nbad = 0;
    while (!m_ovld && cyc < 400) begin
      if (m_sen) nsrc++; else if (m_saddr != 16'd0) nbad++;
      if (m_ren) nrec++; else if (m_raddr != 16'd0) nbad++;
      @(posedge clk); #1;
      cyc++;
    end
    t_av = (yb != 0);
    l_av = (xb != 0);
    r_av = t_av && tr && (xb != 256 / b - 1);
    exp_rec = (t_av ? b : 0) + (r_av ? b : 0) + ((t_av && l_av) ? 1 : 0) + (l_av ? b : 0);
    check_val("latency", 64'(cyc), 64'(b * b + 3 * b + 3));
    check_val("src_reads", 64'(nsrc), 64'(b * b));
    check_val("rec_reads", 64'(nrec), 64'(exp_rec));
    check_val("addr_idle_zero", 64'(nbad), 64'd0);
  endtask

  task automatic check_out(input int b, input int xb, input int yb, input bit tr);
    logic [2047:0] eb;
    logic [255:0]  et;
    logic [135:0]  el;
    build_exp(b, xb, yb, tr, eb, et, el);
    check_val("out_valid", 64'(m_ovld), 64'd1);
    check_vec("blk_pix", m_blk, eb);
    check_vec("top_pix", 2048'(m_top), 2048'(et));
    check_vec("left_pix", 2048'(m_left), 2048'(el));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("out_valid_cleared", 64'(m_ovld), 64'd0);
    check_val("in_ready_after_out", 64'(m_irdy), 64'd1);
  endtask

  initial begin
    int unsigned seed;
    int xb, yb;
    bit tr;
    reset = 1'b0; out_ready = 1'b0; tra = 1'b0; bx = '0; by = '0; ivld = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(m_irdy), 64'd0);
    check_val("rst_out_valid", 64'(m_ovld), 64'd0);
    check_val("rst_src_en", 64'(m_sen), 64'd0);
    check_val("rst_rec_en", 64'(m_ren), 64'd0);
    check_vec("rst_blk_pix", m_blk, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("in_ready_after_rst", 64'(m_irdy), 64'd1);

    // Corner block: every neighbour substituted, no reconstructed reads
    start_req(0, 0, 0, 1'b0);
    wait_done(4, 0, 0, 1'b0);
    check_out(4, 0, 0, 1'b0);
    release_out();

    // Interior block with all neighbours available
    start_req(0, 2, 3, 1'b1);
    wait_done(4, 2, 3, 1'b1);
    check_out(4, 2, 3, 1'b1);
    release_out();

    // Last column at BLK=8: top-right replicated from top[7]
    start_req(1, 31, 1, 1'b1);
    wait_done(8, 31, 1, 1'b1);
    check_out(8, 31, 1, 1'b1);
    release_out();

    // Back-pressure: result held for 10 cycles, then immediate follow-on request
    start_req(0, 5, 7, 1'b1);
    wait_done(4, 5, 7, 1'b1);
    repeat (10) begin
      check_out(4, 5, 7, 1'b1);
      check_val("in_ready_busy", 64'(m_irdy), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("out_valid_after_hs", 64'(m_ovld), 64'd0);
    start_req(0, 1, 0, 1'b1);
    wait_done(4, 1, 0, 1'b1);
    check_out(4, 1, 0, 1'b1);
    release_out();

    // Reset in the middle of a fetch
    start_req(0, 9, 4, 1'b1);
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("midrst_out_valid", 64'(m_ovld), 64'd0);
    check_val("midrst_src_en", 64'(m_sen), 64'd0);
    check_val("midrst_rec_en", 64'(m_ren), 64'd0);
    check_val("midrst_in_ready", 64'(m_irdy), 64'd0);
    check_vec("midrst_blk_pix", m_blk, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_in_ready_rel", 64'(m_irdy), 64'd1);
    start_req(0, 63, 63, 1'b1);
    wait_done(4, 63, 63, 1'b1);
    check_out(4, 63, 63, 1'b1);
    release_out();

    // BLK=16 back-to-back stream, frame edges first then pseudo-random blocks
    out_ready = 1'b1;
    seed = 32'h1234_5678;
    for (int r = 0; r < 40; r++) begin
      seed = seed * 32'd1103515245 + 32'd12345;
      xb = int'((seed >> 16) & 32'hF);
      yb = int'((seed >> 20) & 32'hF);
      tr = seed[27];
      if (r == 0) begin xb = 0;  yb = 0;  end
      if (r == 1) begin xb = 15; yb = 0;  end
      if (r == 2) begin xb = 0;  yb = 15; end
      if (r == 3) begin xb = 15; yb = 15; tr = 1'b1; end
      start_req(2, xb, yb, tr);
      wait_done(16, xb, yb, tr);
      check_out(16, xb, yb, tr);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check_val("stream_out_valid_cleared", 64'(m_ovld), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
